// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// One bit per cycle: shift-add multiply and restoring divide, then sign fix.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q;
    logic               qsign_q;
    logic               rsign_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               sgn_op;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               qbit;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand magnitudes, one iteration step of each algorithm, and sign fix.
    always_comb begin
        sgn_op  = ~op[0];
        a_abs   = (sgn_op && A[WIDTH-1]) ? -A : A;
        b_abs   = (sgn_op && B[WIDTH-1]) ? -B : B;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {sum, acc_q[WIDTH-1:1]};
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        qbit    = (shifted >= {1'b0, opnd_q});
        diff    = shifted[WIDTH-1:0] - opnd_q;
        div_nxt = {(qbit ? diff : shifted[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], qbit};
        prod_fix = qsign_q ? -acc_q : acc_q;
        quo_fix  = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        unique case (op)
                            3'd4: hi_q <= A;
                            3'd5: lo_q <= A;
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div_q <= op[1];
                                qsign_q  <= sgn_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                                rsign_q  <= sgn_op & A[WIDTH-1];
                                opnd_q   <= op[1] ? b_abs : a_abs;
                                acc_q    <= {{WIDTH{1'b0}},
                                             (op[1] ? a_abs : b_abs)};
                                cnt_q    <= CW'(WIDTH);
                                state_q  <= CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc_q <= is_div_q ? div_nxt : mul_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_q <= FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32.
// Expected values are hand-computed constants.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_bad;
    int lat;

    mul_div_unit #(.WIDTH(32), .CW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; return in cycle 1 with garbage operands.
    task automatic kick(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Run one mul/div to its done cycle and check latency, busy span, result.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit inj, output int cyc_o);
        int cyc;
        int bcnt;
        kick(o, a, b);
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc < 60) begin
            if (busy) bcnt++;
            if (inj && cyc == 5) begin
                start = 1'b1;
                op    = 3'd5;
                A     = 32'h0000ABCD;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, cyc, 34);
        chk({tag, "_busycyc"}, bcnt, 33);
        chk({tag, "_busy_in_done"}, {31'b0, busy}, 0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        cyc_o = cyc;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd7;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0, lat);
        @(posedge clk);
        #1;
        chk("multu_done_1cyc", {31'b0, done}, 0);

        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00000007,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, lat);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h00000002,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, lat);
        run_op("div_negdvsr", 3'd2, 32'h00000007, 32'hFFFFFFFE,
               32'h00000001, 32'hFFFFFFFD, 1'b0, lat);
        run_op("mult_minmin", 3'd0, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 1'b0, lat);
        run_op("divu_zero", 3'd3, 32'h00000064, 32'h00000000,
               32'h00000064, 32'hFFFFFFFF, 1'b0, lat);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 1'b0, lat);

        @(posedge clk);
        #1;
        kick(3'd4, 32'h12345678, 32'h0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'b0, busy}, 0);
        chk("mthi_done", {31'b0, done}, 0);
        kick(3'd6, 32'hDEADBEEF, 32'h0);
        chk("nop_busy", {31'b0, busy}, 0);
        chk("nop_hi", hi, 32'h12345678);
        chk("nop_lo", lo, 32'h80000000);

        run_op("mtlo_ignored", 3'd1, 32'hFFFFFFFF, 32'h00000002,
               32'h00000001, 32'hFFFFFFFE, 1'b1, lat);

        @(posedge clk);
        #1;
        kick(3'd3, 32'h000003E8, 32'h00000007);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op("post_rst", 3'd1, 32'h00000003, 32'h00000005,
               32'h00000000, 32'h0000000F, 1'b0, lat);

        run_op("b2b_mul", 3'd1, 32'h00000002, 32'h00000003,
               32'h00000000, 32'h00000006, 1'b0, lat);
        run_op("b2b_div", 3'd3, 32'h00000009, 32'h00000002,
               32'h00000001, 32'h00000004, 1'b0, lat);
        chk("b2b_gap", lat - 1, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
